// File: rtl/key_event_pkg.sv
// key_event_pkg
//   Shared types and constants for the key event classifier.
//   state_t       : classifier FSM states
//   MS_CNT_W      : width of the millisecond counter
//   ms_to_cycles  : sys_clk cycles per millisecond (never less than 1)
package key_event_pkg;

  localparam int MS_CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRESS1 = 3'd1,
    ST_WAIT2  = 3'd2,
    ST_PRESS2 = 3'd3,
    ST_LONG   = 3'd4
  } state_t;

  // A clock slower than 1 kHz still gets a tick every cycle rather than
  // a zero-length period.
  function automatic int unsigned ms_to_cycles(input int unsigned clk_freq);
    int unsigned cyc;
    cyc = clk_freq / 1000;
    return (cyc < 1) ? 1 : cyc;
  endfunction

endpackage

// File: rtl/key_event_classifier_ms_tick.sv
// ms_tick_gen
//   Millisecond tick generator. Counts 0..cycles_per_ms-1 and asserts tick
//   while the count sits at its terminal value.
//   sys_clk   in  system clock
//   sys_rst_n in  async active-low reset
//   clr       in  restart the millisecond period from zero
//   tick      out one-cycle pulse once per millisecond
module ms_tick_gen
  import key_event_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CYC_PER_MS = ms_to_cycles(CLK_FREQ);
  localparam int          CNT_W      = (CYC_PER_MS > 1) ? $clog2(CYC_PER_MS) : 1;
  localparam logic [CNT_W-1:0] TC    = CNT_W'(CYC_PER_MS - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt <= '0;
    end else if (clr || (cnt == TC)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == TC);

endmodule

// File: rtl/key_event_classifier.sv
// key_event_classifier
//   Turns debounced key strobes into short / double / long / repeat command
//   pulses for the stepper and parking control FSMs.
//   sys_clk      in  system clock
//   sys_rst_n    in  async active-low reset
//   key_flag     in  one-cycle strobe: debounced level settled
//   key_value    in  debounced level (0 = pressed), valid with key_flag
//   short_pulse  out one cycle: single short click
//   double_pulse out one cycle: double click
//   long_pulse   out one cycle: long-press threshold reached
//   repeat_pulse out one cycle: periodic pulse while long-held
//   key_held     out level: key considered pressed
//
// state  | meaning
// IDLE   | no gesture in progress
// PRESS1 | first press held, timing toward long press
// WAIT2  | released, waiting for a possible second press
// PRESS2 | second press of a double click held
// LONG   | long press held, emitting repeats
module key_event_classifier
  import key_event_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned LONG_MS   = 1000,
  parameter int unsigned DCLICK_MS = 300,
  parameter int unsigned REPEAT_MS = 200
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_flag,
  input  logic key_value,
  output logic short_pulse,
  output logic double_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic key_held
);

  localparam logic [MS_CNT_W-1:0] LONG_LIM   = MS_CNT_W'(LONG_MS);
  localparam logic [MS_CNT_W-1:0] DCLICK_LIM = MS_CNT_W'(DCLICK_MS);
  localparam logic [MS_CNT_W-1:0] REPEAT_LIM = MS_CNT_W'(REPEAT_MS);

  state_t              state;
  logic [MS_CNT_W-1:0] ms_cnt;
  logic                tick;
  logic                prs_ev;
  logic                rel_ev;
  logic                long_hit;
  logic                dclick_hit;
  logic                repeat_hit;
  logic                leave;
  logic                repeat_fire;

  always_comb begin
    prs_ev      = key_flag & ~key_value;
    rel_ev      = key_flag & key_value;
    long_hit    = (ms_cnt >= LONG_LIM);
    dclick_hit  = (ms_cnt >= DCLICK_LIM);
    repeat_hit  = (ms_cnt >= REPEAT_LIM);
    // Release beats a coincident repeat.
    repeat_fire = (state == ST_LONG) & repeat_hit & ~rel_ev;
    // leave mirrors every transition taken by the FSM below; it restarts
    // both the tick phase and ms_cnt on the same edge as the state change.
    leave = 1'b0;
    case (state)
      ST_IDLE:   leave = prs_ev;
      ST_PRESS1: leave = rel_ev | long_hit;
      ST_WAIT2:  leave = prs_ev | dclick_hit;
      ST_PRESS2: leave = rel_ev;
      ST_LONG:   leave = rel_ev;
      default:   leave = 1'b1;
    endcase
  end

  ms_tick_gen #(
    .CLK_FREQ (CLK_FREQ)
  ) u_ms_tick (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .clr       (leave),
    .tick      (tick)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ms_cnt <= '0;
    end else if (leave || repeat_fire) begin
      ms_cnt <= '0;
    end else if (tick && (ms_cnt != '1)) begin
      ms_cnt <= ms_cnt + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state        <= ST_IDLE;
      short_pulse  <= 1'b0;
      double_pulse <= 1'b0;
      long_pulse   <= 1'b0;
      repeat_pulse <= 1'b0;
      key_held     <= 1'b0;
    end else begin
      short_pulse  <= 1'b0;
      double_pulse <= 1'b0;
      long_pulse   <= 1'b0;
      repeat_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (prs_ev) begin
            state    <= ST_PRESS1;
            key_held <= 1'b1;
          end
        end
        ST_PRESS1: begin
          if (long_hit) begin
            state      <= ST_LONG;
            long_pulse <= 1'b1;
          end else if (rel_ev) begin
            key_held <= 1'b0;
            // With no double-click window the click is final on release.
            if (DCLICK_MS == 0) begin
              state       <= ST_IDLE;
              short_pulse <= 1'b1;
            end else begin
              state <= ST_WAIT2;
            end
          end
        end
        ST_WAIT2: begin
          if (dclick_hit) begin
            state       <= ST_IDLE;
            short_pulse <= 1'b1;
          end else if (prs_ev) begin
            state        <= ST_PRESS2;
            double_pulse <= 1'b1;
            key_held     <= 1'b1;
          end
        end
        ST_PRESS2: begin
          if (rel_ev) begin
            state    <= ST_IDLE;
            key_held <= 1'b0;
          end
        end
        ST_LONG: begin
          if (rel_ev) begin
            state    <= ST_IDLE;
            key_held <= 1'b0;
          end else if (repeat_hit) begin
            repeat_pulse <= 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          key_held <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_event_classifier.sv
module tb_key_event_classifier;

  localparam int CPM        = 10;
  localparam int LONG_CYC   = 20 * CPM;
  localparam int DCLK_CYC   = 5 * CPM;
  localparam int REP_CYC    = 4 * CPM;

  localparam int K_SHORT  = 0;
  localparam int K_DOUBLE = 1;
  localparam int K_LONG   = 2;
  localparam int K_REPEAT = 3;

  typedef struct {
    string name;
    int    hold1;  // press-to-release, cycles
    int    dup;    // redundant press strobe offset (0 = none)
    int    gap;    // release-to-second-press, cycles (0 = none)
    int    hold2;  // second press length, cycles
  } vec_t;

  typedef struct {
    int kind;
    int cyc;
  } exp_t;

  logic sys_clk = 1'b0;
  logic sys_rst_n;
  logic key_flag;
  logic key_value;
  logic short_pulse, double_pulse, long_pulse, repeat_pulse, key_held;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  vec_t vecs[9];
  int   mon_n;
  int   mon_kind;
  exp_t mon_e;

  key_event_classifier #(
    .CLK_FREQ  (10_000),
    .LONG_MS   (20),
    .DCLICK_MS (5),
    .REPEAT_MS (4)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .key_flag     (key_flag),
    .key_value    (key_value),
    .short_pulse  (short_pulse),
    .double_pulse (double_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse),
    .key_held     (key_held)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic push(input int kind, input int at);
    exp_t e;
    e.kind = kind;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  // Pulse monitor: each observed pulse is matched against the oldest
  // expected event; cycle = edge that registered the pulse.
  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      mon_n = int'(short_pulse) + int'(double_pulse) + int'(long_pulse) + int'(repeat_pulse);
      if (mon_n != 0) begin
        checks++;
        mon_kind = short_pulse ? K_SHORT : double_pulse ? K_DOUBLE :
                   long_pulse ? K_LONG : K_REPEAT;
        if (mon_n > 1) begin
          errors++;
          $display("FAIL onehot pulses=%0d required=1 cyc=%0d", mon_n, cyc);
        end else if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse kind=%0d cyc=%0d required=none", mon_kind, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.kind != mon_kind || cyc < mon_e.cyc || cyc > mon_e.cyc + 1) begin
            errors++;
            $display("FAIL pulse kind=%0d cyc=%0d required kind=%0d cyc=%0d",
                     mon_kind, cyc, mon_e.kind, mon_e.cyc);
          end
        end
      end
    end
  end

  task automatic adv(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  // Called at posedge+1; the strobe is sampled by the next edge.
  task automatic strobe(input logic lvl, output int edge_n);
    key_flag  = 1'b1;
    key_value = lvl;
    @(posedge sys_clk);
    #1;
    edge_n    = cyc;
    key_flag  = 1'b0;
    key_value = 1'b1;
  endtask

  task automatic strobe_at(input int target, input logic lvl, output int edge_n);
    adv(target - cyc - 1);
    strobe(lvl, edge_n);
  endtask

  task automatic run_vec(input vec_t v);
    int t0, tr, tp, tq, td;
    strobe(1'b0, t0);
    chk({v.name, "/held_press"}, int'(key_held), 1);
    tr = t0 + v.hold1;
    if (v.hold1 >= LONG_CYC + 1) begin
      push(K_LONG, t0 + LONG_CYC + 1);
      for (int e = t0 + LONG_CYC + 1 + REP_CYC + 1; e < tr; e += REP_CYC)
        push(K_REPEAT, e);
    end else if (v.gap > 0 && v.gap <= DCLK_CYC) begin
      push(K_DOUBLE, tr + v.gap);
    end else begin
      push(K_SHORT, tr + DCLK_CYC + 1);
      if (v.gap > 0) push(K_SHORT, tr + v.gap + v.hold2 + DCLK_CYC + 1);
    end
    if (v.dup > 0) begin
      strobe_at(t0 + v.dup, 1'b0, td);
      chk({v.name, "/held_dup"}, int'(key_held), 1);
    end
    strobe_at(tr, 1'b1, tq);
    chk({v.name, "/held_rel"}, int'(key_held), 0);
    if (v.gap > 0) begin
      strobe_at(tr + v.gap, 1'b0, tp);
      chk({v.name, "/held_press2"}, int'(key_held), 1);
      strobe_at(tp + v.hold2, 1'b1, tq);
      chk({v.name, "/held_rel2"}, int'(key_held), 0);
    end
    adv(DCLK_CYC + 30);
    chk({v.name, "/pending"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int t0, tr;
    vecs[0] = '{"short",        50,  0,  0,  0};
    vecs[1] = '{"double",       30,  0, 20, 30};
    vecs[2] = '{"long_repeat", 350,  0,  0,  0};
    vecs[3] = '{"gap_6ms",      30,  0, 60, 30};
    vecs[4] = '{"redundant",    40, 20,  0,  0};
    vecs[5] = '{"gap_edge",     30,  0, 50, 30};
    vecs[6] = '{"hold_edge",   200,  0,  0,  0};
    vecs[7] = '{"rep_vs_rel",  242,  0,  0,  0};
    vecs[8] = '{"rep_first",   243,  0,  0,  0};

    sys_rst_n = 1'b0;
    key_flag  = 1'b0;
    key_value = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_short",  int'(short_pulse), 0);
    chk("rst_double", int'(double_pulse), 0);
    chk("rst_long",   int'(long_pulse), 0);
    chk("rst_repeat", int'(repeat_pulse), 0);
    chk("rst_held",   int'(key_held), 0);
    sys_rst_n = 1'b1;
    adv(5);

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Reset in the middle of a press discards the gesture.
    strobe(1'b0, t0);
    chk("midrst/held_press", int'(key_held), 1);
    adv(99);
    sys_rst_n = 1'b0;
    #1;
    chk("midrst/held_in_rst", int'(key_held), 0);
    chk("midrst/pulses_in_rst",
        int'(short_pulse) + int'(double_pulse) + int'(long_pulse) + int'(repeat_pulse), 0);
    adv(3);
    sys_rst_n = 1'b1;
    strobe(1'b1, tr);
    chk("midrst/held_after", int'(key_held), 0);
    adv(LONG_CYC + 100);
    chk("midrst/no_pulse", exp_q.size(), 0);
    chk("midrst/held_idle", int'(key_held), 0);
    // The FSM is back in IDLE: a fresh click behaves as a plain short click.
    strobe(1'b0, t0);
    chk("midrst/held_new", int'(key_held), 1);
    strobe_at(t0 + 30, 1'b1, tr);
    push(K_SHORT, tr + DCLK_CYC + 1);
    adv(DCLK_CYC + 30);
    chk("midrst/short_seen", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_event_classifier.md
Name: key_event_classifier

Overview:
- Sits directly downstream of the key debouncer in the stepper-control path.
- Consumes the debouncer's one-cycle valid strobe and settled key level.
- Classifies each key gesture as short press, double click, long press, or auto-repeat while held.
- Emits one-cycle event pulses that the stepper/parking control FSMs use as commands.

Parameters:
- CLK_FREQ, 50_000_000: sys_clk frequency in Hz.
- LONG_MS, 1000: hold time in ms before a press counts as long.
- DCLICK_MS, 300: maximum release gap in ms for a second press to count as a double click.
- REPEAT_MS, 200: repeat_pulse period in ms while in long-hold.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  reset.
- key_flag  in  1  one-cycle strobe: debounced level has settled.
- key_value  in  1  debounced level, sampled only when key_flag=1. 0=pressed, 1=released.
- short_pulse  out  1  one cycle: single short click.
- double_pulse  out  1  one cycle: double click.
- long_pulse  out  1  one cycle: long-press threshold reached.
- repeat_pulse  out  1  one cycle: periodic pulse during long hold.
- key_held  out  1  level: key currently considered pressed.

Behaviour:
- Reset is asynchronous, active-low, on sys_rst_n; clock is sys_clk.
- On reset: all outputs 0, FSM=IDLE, tick and ms counters 0.
- Reset mid-gesture discards the gesture; no pulse is emitted.
- ms tick generator:
  - Counts 0..CLK_FREQ/1000-1 and emits a one-cycle tick at the terminal count.
  - Clears on every FSM state change, so all timings are accurate to within 1 ms + 1 cycle.
- ms_cnt:
  - 16-bit, increments on tick, saturates at 0xFFFF.
  - Cleared on every state change and on every repeat_pulse.
- Event definitions:
  - "press" = key_flag & ~key_value.
  - "release" = key_flag & key_value.
  - A strobe that repeats the current level (e.g. press seen in PRESS1) is ignored.
- FSM states and transitions (all outputs registered; pulses assert exactly one cycle, in the cycle after the triggering condition):
  - IDLE: press -> PRESS1.
  - PRESS1:
    - release with ms_cnt < LONG_MS -> WAIT2.
    - ms_cnt >= LONG_MS -> LONG, long_pulse.
  - WAIT2:
    - press with ms_cnt < DCLICK_MS -> PRESS2, double_pulse.
    - ms_cnt >= DCLICK_MS -> IDLE, short_pulse.
    - If DCLICK_MS=0, a release in PRESS1 goes straight to IDLE with short_pulse.
  - PRESS2: release -> IDLE, no pulse. No long detection in this state.
  - LONG:
    - Each time ms_cnt reaches REPEAT_MS: repeat_pulse, ms_cnt cleared.
    - release -> IDLE, no pulse.
    - If release and repeat coincide in the same cycle, release wins and repeat_pulse is suppressed.
- key_held = 1 in PRESS1, PRESS2, LONG; 0 otherwise. Registered, so it updates 1 cycle after the strobe.
- At most one of the four pulse outputs is high in any cycle.
- Threshold compares use >=, so parameters of 0 or 1 behave deterministically.
- Illegal or unused state encodings return to IDLE with no pulse.

Decomposition:
- Package key_event_pkg:
  - State enum (IDLE, PRESS1, WAIT2, PRESS2, LONG).
  - Function ms_to_cycles(CLK_FREQ).
  - MS_CNT_W=16 constant.
- Sub-module ms_tick_gen, with ports sys_clk, sys_rst_n, clr, tick, parameterised by CLK_FREQ.
- The FSM, ms_cnt and output registers live in the top module.

Test Plan:
All scenarios use CLK_FREQ=10_000 (10 cycles/ms), LONG_MS=20, DCLICK_MS=5, REPEAT_MS=4.
- Short click: press, release after 5 ms, no further strobe -> exactly one short_pulse about 5 ms after release. key_held is high during the press. No other pulses.
- Double click: press, release at 3 ms, press 2 ms later -> double_pulse 1 cycle after the second strobe, no short_pulse. After the second release, outputs stay 0.
- Long + repeat: press held 35 ms -> long_pulse at ~20 ms, then repeat_pulse at ~24, 28, 32 ms. Release -> key_held drops, no further pulses.
- Gap boundary: release-to-press gap = 6 ms (> DCLICK_MS) -> short_pulse at 5 ms. The second press then starts a new PRESS1 gesture with no double_pulse.
- Redundant strobes: two consecutive press strobes 2 ms apart, then release at 4 ms -> treated as a single short click and a single short_pulse.
- Reset mid-gesture: press, assert sys_rst_n low at 10 ms for 3 cycles, then release -> all outputs 0, no pulse after reset, FSM back in IDLE.
